// File: rtl/tt_wb_ctrl_seq.sv
// tt_wb_ctrl_seq: Wishbone slave that sequences the tt_top mux control chain
// (select-chain reset, N increment pulses, then enable) and reports progress.
module tt_wb_ctrl_seq #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          ADDR_W    = 10,
    parameter int          PULSE_LEN = 2,
    parameter int          GAP_LEN   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        ctrl_sel_rst_n,
    output logic        ctrl_sel_inc,
    output logic        ctrl_ena,
    output logic        busy,
    output logic        done_irq
);
    localparam int MAXL = PULSE_LEN > GAP_LEN ? PULSE_LEN : GAP_LEN;
    localparam int CW   = $clog2(MAXL) + 1;
    localparam logic [CW-1:0] P1 = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] G1 = CW'(GAP_LEN - 1);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RST_LO  = 3'd1;
    localparam logic [2:0] RST_GAP = 3'd2;
    localparam logic [2:0] INC_HI  = 3'd3;
    localparam logic [2:0] INC_GAP = 3'd4;
    localparam logic [2:0] ENA_S   = 3'd5;

    logic [2:0]        state, nxt;
    logic [CW-1:0]     cnt, ncnt;
    logic [ADDR_W-1:0] cur, ncur;
    logic [31:0]       ctrl_q, stat, rdata;
    logic              err, hit, rd, ctrl_wr, full, start, err_set, stat_rd;
    logic              unused_adr;

    assign unused_adr = ^wbs_adr_i[1:0];
    assign hit     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & !wbs_ack_o;
    assign rd      = hit & !wbs_we_i;
    assign full    = wbs_sel_i == 4'hF;
    assign ctrl_wr = hit & wbs_we_i & (wbs_adr_i[3:2] == 2'd0);
    assign start   = ctrl_wr & full & !busy;
    assign err_set = ctrl_wr & full & busy;
    assign stat_rd = rd & (wbs_adr_i[3:2] == 2'd1);

    always_comb begin
        stat = '0;
        stat[0] = busy;
        stat[1] = ctrl_ena;
        stat[2] = err;
        stat[16+:ADDR_W] = cur;
        rdata = wbs_adr_i[3:2] == 2'd0 ? ctrl_q : wbs_adr_i[3:2] == 2'd1 ? stat : '0;
    end

    // One shared down-counter times every pulse and gap; a phase ends when it hits 0.
    always_comb begin
        nxt  = state;
        ncnt = cnt - CW'(1);
        ncur = cur;
        case (state)
            RST_LO:  if (cnt == '0) begin nxt = RST_GAP; ncnt = G1; end
            RST_GAP: if (cnt == '0) begin nxt = ctrl_q[ADDR_W-1:0] == '0 ? ENA_S : INC_HI; ncnt = P1; end
            INC_HI:  if (cnt == '0) begin nxt = INC_GAP; ncnt = G1; ncur = cur + ADDR_W'(1); end
            INC_GAP: if (cnt == '0) begin nxt = cur == ctrl_q[ADDR_W-1:0] ? ENA_S : INC_HI; ncnt = P1; end
            ENA_S:   begin nxt = IDLE; ncnt = cnt; end
            default: begin nxt = IDLE; ncnt = cnt; end
        endcase
        if (start) begin
            nxt  = RST_LO;
            ncnt = P1;
            ncur = '0;
        end
    end

    // Control outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbs_ack_o      <= 1'b0;
            wbs_dat_o      <= '0;
            ctrl_q         <= '0;
            err            <= 1'b0;
            state          <= IDLE;
            cnt            <= '0;
            cur            <= '0;
            busy           <= 1'b0;
            ctrl_sel_rst_n <= 1'b0;
            ctrl_sel_inc   <= 1'b0;
            ctrl_ena       <= 1'b0;
            done_irq       <= 1'b0;
        end else begin
            wbs_ack_o      <= hit;
            wbs_dat_o      <= rd ? rdata : '0;
            ctrl_q         <= start ? wbs_dat_i : ctrl_q;
            err            <= err_set | (err & !stat_rd);
            state          <= nxt;
            cnt            <= ncnt;
            cur            <= ncur;
            busy           <= nxt != IDLE;
            ctrl_sel_rst_n <= nxt != RST_LO;
            ctrl_sel_inc   <= nxt == INC_HI;
            ctrl_ena       <= nxt == ENA_S ? ctrl_q[31] : nxt == RST_LO ? 1'b0 : ctrl_ena;
            done_irq       <= nxt == ENA_S;
        end
    end
endmodule

// File: tb/tb_tt_wb_ctrl_seq.sv
// tb_tt_wb_ctrl_seq: self-checking bench for tt_wb_ctrl_seq against a
// timeline model of the control sequence derived from N, PULSE_LEN and GAP_LEN.
module tb_tt_wb_ctrl_seq;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int P = 2;
    localparam int G = 2;

    logic        clk = 0, rst_n = 0;
    logic        stb = 0, cyc = 0, we = 0;
    logic [3:0]  sel = 0;
    logic [31:0] adr = 0, dat = 0;
    logic        ack, sel_rst_n, sel_inc, ena, busy, done_irq;
    logic [31:0] dat_o;
    int          tests = 0, fails = 0;

    tt_wb_ctrl_seq #(.BASE_ADDR(BASE), .ADDR_W(10), .PULSE_LEN(P), .GAP_LEN(G)) dut (
        .clk(clk), .rst_n(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .ctrl_sel_rst_n(sel_rst_n), .ctrl_sel_inc(sel_inc), .ctrl_ena(ena), .busy(busy),
        .done_irq(done_irq)
    );

    always #5 clk = ~clk;

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic got);
        @(posedge clk); #1;
        stb = 1; cyc = 1; we = 1; adr = a; dat = d; sel = s;
        @(posedge clk); #1;
        got = ack;
        stb = 0; cyc = 0; we = 0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output logic got);
        @(posedge clk); #1;
        stb = 1; cyc = 1; we = 0; adr = a; sel = 4'hF;
        @(posedge clk); #1;
        got = ack; d = dat_o;
        stb = 0; cyc = 0;
    endtask

    // Called at t=0 (just after the ack edge of an accepted CTRL write).
    task automatic check_seq(input int n, input logic en, input logic inj, input string nm);
        int b, u, hi;
        logic [4:0] exp_v, obs;
        logic [31:0] rd, exp_stat;
        logic got;
        b = (n + 1) * (P + G) + 1;
        hi = 0;
        for (int t = 0; t < b + 2; t++) begin
            u = t - (P + G);
            exp_v = {t < b, t >= P,
                     t >= P + G && u / (P + G) < n && u % (P + G) < P && t < b,
                     t == b - 1, t >= b - 1 ? en : 1'b0};
            obs = {busy, sel_rst_n, sel_inc, done_irq, ena};
            hi += busy;
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL %s wave t=%0d got %b want %b (busy,rst_n,inc,done,ena)", nm, t, obs, exp_v);
            end
            if (inj && t == 4) begin
                tests++;
                if (ack !== 1'b1) begin
                    fails++;
                    $display("FAIL %s busy_write_ack got %b want 1", nm, ack);
                end
                stb = 0; cyc = 0; we = 0;
            end
            if (inj && t == 3) begin
                stb = 1; cyc = 1; we = 1; adr = BASE; dat = 32'h8000_0007; sel = 4'hF;
            end
            @(posedge clk); #1;
        end
        tests++;
        if (hi !== b) begin
            fails++;
            $display("FAIL %s busy_len got %0d want %0d", nm, hi, b);
        end
        wb_read(BASE + 4, rd, got);
        exp_stat = (32'(n) << 16) | (32'(inj) << 2) | (32'(en) << 1);
        tests++;
        if (got !== 1'b1 || rd !== exp_stat) begin
            fails++;
            $display("FAIL %s stat got ack=%b %h want ack=1 %h", nm, got, rd, exp_stat);
        end
    endtask

    task automatic start_seq(input int n, input logic en, input string nm);
        logic got;
        wb_write(BASE, {en, 21'd0, 10'(n)}, 4'hF, got);
        tests++;
        if (got !== 1'b1) begin
            fails++;
            $display("FAIL %s start_ack got %b want 1", nm, got);
        end
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        logic got;
        #2;
        tests++;
        if ({ack, dat_o, sel_rst_n, sel_inc, ena, busy, done_irq} !== 38'd0) begin
            fails++;
            $display("FAIL reset_init got ack=%b dat=%h rst_n=%b inc=%b ena=%b busy=%b done=%b want all 0",
                     ack, dat_o, sel_rst_n, sel_inc, ena, busy, done_irq);
        end
        #20 rst_n = 1;
        @(posedge clk); #1;
        tests++;
        if (sel_rst_n !== 1'b1) begin
            fails++;
            $display("FAIL reset_release rst_n got %b want 1", sel_rst_n);
        end
        start_seq(5, 1'b1, "reset_mid");
        repeat (4) begin @(posedge clk); #1; end
        tests++;
        if (sel_inc !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_pre got inc=%b busy=%b want 1 1", sel_inc, busy);
        end
        #1 rst_n = 0;
        #1;
        tests++;
        if ({ack, dat_o, sel_rst_n, sel_inc, ena, busy, done_irq} !== 38'd0) begin
            fails++;
            $display("FAIL reset_mid_async got rst_n=%b inc=%b ena=%b busy=%b done=%b want all 0",
                     sel_rst_n, sel_inc, ena, busy, done_irq);
        end
        #10 rst_n = 1;
        @(posedge clk); #1;
        tests++;
        if (sel_rst_n !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_release got rst_n=%b busy=%b want 1 0", sel_rst_n, busy);
        end
        wb_read(BASE + 4, rd, got);
        tests++;
        if (got !== 1'b1 || rd !== 32'd0) begin
            fails++;
            $display("FAIL reset_mid_stat got ack=%b %h want ack=1 0", got, rd);
        end
    endtask

    task automatic test_basic;
        start_seq(3, 1'b1, "n3_ena");
        check_seq(3, 1'b1, 1'b0, "n3_ena");
        start_seq(0, 1'b0, "n0");
        check_seq(0, 1'b0, 1'b0, "n0");
    endtask

    task automatic test_busy_write;
        logic [31:0] rd;
        logic got;
        start_seq(2, 1'b1, "busy_wr");
        check_seq(2, 1'b1, 1'b1, "busy_wr");
        wb_read(BASE + 4, rd, got);
        tests++;
        if (rd[2] !== 1'b0) begin
            fails++;
            $display("FAIL busy_wr_err_clear got %b want 0", rd[2]);
        end
        wb_read(BASE, rd, got);
        tests++;
        if (rd !== 32'h8000_0002) begin
            fails++;
            $display("FAIL busy_wr_ctrl got %h want 80000002", rd);
        end
    endtask

    task automatic test_reject;
        logic [31:0] rd;
        logic got;
        wb_write(BASE, 32'h8000_0009, 4'h3, got);
        tests++;
        if (got !== 1'b1) begin
            fails++;
            $display("FAIL partial_ack got %b want 1", got);
        end
        repeat (3) begin
            @(posedge clk); #1;
            tests++;
            if (busy !== 1'b0 || sel_rst_n !== 1'b1) begin
                fails++;
                $display("FAIL partial_noseq got busy=%b rst_n=%b want 0 1", busy, sel_rst_n);
            end
        end
        wb_read(BASE + 4, rd, got);
        tests++;
        if (rd[2] !== 1'b0) begin
            fails++;
            $display("FAIL partial_err got %b want 0", rd[2]);
        end
        stb = 1; cyc = 1; we = 0; adr = BASE + 32'h10;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            tests++;
            if (ack !== 1'b0 || dat_o !== 32'd0) begin
                fails++;
                $display("FAIL nomatch cycle %0d got ack=%b dat=%h want 0 0", i, ack, dat_o);
            end
        end
        stb = 0; cyc = 0;
    endtask

    task automatic test_back_to_back;
        logic exp_a;
        @(posedge clk); #1;
        stb = 1; cyc = 1; we = 0; adr = BASE + 8;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            exp_a = (i % 2) == 0;
            tests++;
            if (ack !== exp_a || dat_o !== 32'd0) begin
                fails++;
                $display("FAIL b2b cycle %0d got ack=%b dat=%h want %b 0", i, ack, dat_o, exp_a);
            end
        end
        stb = 0; cyc = 0;
    endtask

    task automatic test_max_n;
        start_seq(1023, 1'b1, "n1023");
        check_seq(1023, 1'b1, 1'b0, "n1023");
    endtask

    task automatic test_random;
        int n;
        logic en;
        logic [31:0] rd;
        logic got;
        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(0, 40);
            en = 1'($urandom_range(0, 1));
            start_seq(n, en, "rand");
            check_seq(n, en, 1'b0, "rand");
            wb_read(BASE, rd, got);
            tests++;
            if (rd !== {en, 21'd0, 10'(n)}) begin
                fails++;
                $display("FAIL rand_ctrl got %h want %h", rd, {en, 21'd0, 10'(n)});
            end
            wb_read(BASE + 12, rd, got);
            tests++;
            if (got !== 1'b1 || rd !== 32'd0) begin
                fails++;
                $display("FAIL rand_reg3 got ack=%b %h want 1 0", got, rd);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_busy_write;
        test_reject;
        test_back_to_back;
        test_random;
        test_max_n;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
